// File: rtl/read_exec_latch.sv
// Read-to-Execute pipeline register with a per-register RAW scoreboard.
// Generates the stall that holds Read and flags protocol errors (sticky).
module read_exec_latch #(
    parameter int CTRL_W = 512,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              readValidIn,
    input  logic [63:0]       operandVal1In,
    input  logic [63:0]       operandVal2In,
    input  logic [63:0]       destRegValueIn,
    input  logic [3:0]        destRegIn,
    input  logic              destRegValidIn,
    input  logic [CTRL_W-1:0] ctrlIn,
    input  logic [3:0]        decSrc1In,
    input  logic [3:0]        decSrc2In,
    input  logic [3:0]        decDestIn,
    input  logic              decSrc1ValidIn,
    input  logic              decSrc2ValidIn,
    input  logic              decDestValidIn,
    input  logic              exReadyIn,
    input  logic              wbRetireValidIn,
    input  logic [3:0]        wbRetireRegIn,
    input  logic              flushIn,
    output logic              validOut,
    output logic [63:0]       operandVal1Out,
    output logic [63:0]       operandVal2Out,
    output logic [63:0]       destRegValueOut,
    output logic [3:0]        destRegOut,
    output logic              destRegValidOut,
    output logic [CTRL_W-1:0] ctrlOut,
    output logic              stallOut,
    output logic              errorOut
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              r_valid;
    logic [63:0]       r_op1;
    logic [63:0]       r_op2;
    logic [63:0]       r_dest_val;
    logic [3:0]        r_dest;
    logic              r_dest_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_error;
    logic [CNT_W-1:0]  r_cnt [16];

    logic              w_hazard;
    logic              w_stall;
    logic              w_accept;
    logic [15:0]       w_uflow;
    logic [CNT_W-1:0]  w_cnt_nxt [16];

    // Hazard looks only at pre-edge counts, so a same-cycle retire releases next cycle.
    always_comb begin
        w_hazard = 1'b0;
        if (decSrc1ValidIn && (r_cnt[decSrc1In] != '0)) w_hazard = 1'b1;
        if (decSrc2ValidIn && (r_cnt[decSrc2In] != '0)) w_hazard = 1'b1;
        if (decDestValidIn && (r_cnt[decDestIn] != '0)) w_hazard = 1'b1;
        if (decDestValidIn && (r_cnt[decDestIn] == CNT_MAX)) w_hazard = 1'b1;
    end

    assign w_stall  = w_hazard || (r_valid && !exReadyIn);
    assign w_accept = readValidIn && !w_stall && !flushIn;

    for (genvar g = 0; g < 16; g++) begin : g_cnt
        logic             w_inc;
        logic             w_dec_wb;
        logic             w_dec_fl;
        logic [CNT_W:0]   w_up;
        logic [CNT_W:0]   w_dec;
        logic [CNT_W:0]   w_diff;

        assign w_inc    = w_accept && destRegValidIn && (destRegIn == 4'(g));
        assign w_dec_wb = wbRetireValidIn && (wbRetireRegIn == 4'(g));
        assign w_dec_fl = flushIn && r_valid && r_dest_valid && (r_dest == 4'(g));
        assign w_up     = {1'b0, r_cnt[g]} + (CNT_W+1)'(w_inc);
        assign w_dec    = (CNT_W+1)'(w_dec_wb) + (CNT_W+1)'(w_dec_fl);
        assign w_diff   = w_up - w_dec;
        assign w_uflow[g] = (w_up < w_dec);
        // Clamp at zero on underflow; saturate if an unguarded increment would wrap.
        assign w_cnt_nxt[g] = w_uflow[g]    ? '0 :
                              w_diff[CNT_W] ? CNT_MAX : w_diff[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid      <= 1'b0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_dest_val   <= '0;
            r_dest       <= '0;
            r_dest_valid <= 1'b0;
            r_ctrl       <= '0;
            r_error      <= 1'b0;
            for (int i = 0; i < 16; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 16; i++) r_cnt[i] <= w_cnt_nxt[i];
            if ((|w_uflow) || (readValidIn && w_stall)) r_error <= 1'b1;
            if (flushIn) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid      <= 1'b1;
                r_op1        <= operandVal1In;
                r_op2        <= operandVal2In;
                r_dest_val   <= destRegValueIn;
                r_dest       <= destRegIn;
                r_dest_valid <= destRegValidIn;
                r_ctrl       <= ctrlIn;
            end else if (r_valid && exReadyIn) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign validOut        = r_valid;
    assign operandVal1Out  = r_op1;
    assign operandVal2Out  = r_op2;
    assign destRegValueOut = r_dest_val;
    assign destRegOut      = r_dest;
    assign destRegValidOut = r_dest_valid;
    assign ctrlOut         = r_ctrl;
    assign stallOut        = w_stall;
    assign errorOut        = r_error;

endmodule

// File: tb/tb_read_exec_latch.sv
// Bench for read_exec_latch: directed scenarios plus randomized traffic,
// all checked against an abstract scoreboard/latch model.
module tb_read_exec_latch;

    localparam int CTRL_W = 512;
    localparam int CMAX   = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              readValidIn;
    logic [63:0]       operandVal1In, operandVal2In, destRegValueIn;
    logic [3:0]        destRegIn;
    logic              destRegValidIn;
    logic [CTRL_W-1:0] ctrlIn;
    logic [3:0]        decSrc1In, decSrc2In, decDestIn;
    logic              decSrc1ValidIn, decSrc2ValidIn, decDestValidIn;
    logic              exReadyIn;
    logic              wbRetireValidIn;
    logic [3:0]        wbRetireRegIn;
    logic              flushIn;
    logic              validOut;
    logic [63:0]       operandVal1Out, operandVal2Out, destRegValueOut;
    logic [3:0]        destRegOut;
    logic              destRegValidOut;
    logic [CTRL_W-1:0] ctrlOut;
    logic              stallOut;
    logic              errorOut;

    read_exec_latch #(.CTRL_W(CTRL_W), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .readValidIn(readValidIn),
        .operandVal1In(operandVal1In), .operandVal2In(operandVal2In),
        .destRegValueIn(destRegValueIn), .destRegIn(destRegIn),
        .destRegValidIn(destRegValidIn), .ctrlIn(ctrlIn),
        .decSrc1In(decSrc1In), .decSrc2In(decSrc2In), .decDestIn(decDestIn),
        .decSrc1ValidIn(decSrc1ValidIn), .decSrc2ValidIn(decSrc2ValidIn),
        .decDestValidIn(decDestValidIn), .exReadyIn(exReadyIn),
        .wbRetireValidIn(wbRetireValidIn), .wbRetireRegIn(wbRetireRegIn),
        .flushIn(flushIn), .validOut(validOut),
        .operandVal1Out(operandVal1Out), .operandVal2Out(operandVal2Out),
        .destRegValueOut(destRegValueOut), .destRegOut(destRegOut),
        .destRegValidOut(destRegValidOut), .ctrlOut(ctrlOut),
        .stallOut(stallOut), .errorOut(errorOut)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic last_stall;

    // Reference model: in-flight writer counts per register and the latch contents.
    int                m_cnt [16];
    bit                m_valid, m_err, m_dvalid;
    logic [63:0]       m_op1, m_op2, m_dval;
    logic [3:0]        m_dest;
    logic [CTRL_W-1:0] m_ctrl;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_stall();
        bit h = 0;
        if (decSrc1ValidIn && m_cnt[decSrc1In] != 0) h = 1;
        if (decSrc2ValidIn && m_cnt[decSrc2In] != 0) h = 1;
        if (decDestValidIn && m_cnt[decDestIn] != 0) h = 1;
        if (decDestValidIn && m_cnt[decDestIn] == CMAX) h = 1;
        return h || (m_valid && !exReadyIn);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 16; r++) m_cnt[r] = 0;
        m_valid = 0; m_err = 0; m_dvalid = 0;
        m_op1 = '0; m_op2 = '0; m_dval = '0; m_dest = '0; m_ctrl = '0;
    endtask

    task automatic idle();
        reset = 1'b1; readValidIn = 0; flushIn = 0; exReadyIn = 1;
        operandVal1In = '0; operandVal2In = '0; destRegValueIn = '0;
        destRegIn = '0; destRegValidIn = 0; ctrlIn = '0;
        decSrc1In = '0; decSrc2In = '0; decDestIn = '0;
        decSrc1ValidIn = 0; decSrc2ValidIn = 0; decDestValidIn = 0;
        wbRetireValidIn = 0; wbRetireRegIn = '0;
    endtask

    // One clock: check stall mid-cycle, advance model at the edge, check registered outputs.
    task automatic step();
        bit es, acc;
        int nc [16];
        @(negedge clk);
        es = model_stall();
        last_stall = stallOut;
        if (reset) chk("stall", {63'd0, stallOut}, {63'd0, es});
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            acc = readValidIn && !es && !flushIn;
            if (readValidIn && es) m_err = 1;
            for (int r = 0; r < 16; r++) begin
                int d, t;
                d = ((wbRetireValidIn && wbRetireRegIn == r) ? 1 : 0) +
                    ((flushIn && m_valid && m_dvalid && m_dest == r) ? 1 : 0);
                t = m_cnt[r] + ((acc && destRegValidIn && destRegIn == r) ? 1 : 0) - d;
                if (t < 0) begin t = 0; m_err = 1; end
                if (t > CMAX) t = CMAX;
                nc[r] = t;
            end
            for (int r = 0; r < 16; r++) m_cnt[r] = nc[r];
            if (flushIn) m_valid = 0;
            else if (acc) begin
                m_valid = 1; m_op1 = operandVal1In; m_op2 = operandVal2In;
                m_dval = destRegValueIn; m_dest = destRegIn;
                m_dvalid = destRegValidIn; m_ctrl = ctrlIn;
            end else if (m_valid && exReadyIn) m_valid = 0;
        end
        #1;
        chk("valid",  {63'd0, validOut}, {63'd0, m_valid});
        chk("op1",    operandVal1Out, m_op1);
        chk("op2",    operandVal2Out, m_op2);
        chk("dval",   destRegValueOut, m_dval);
        chk("dest",   {60'd0, destRegOut}, {60'd0, m_dest});
        chk("dvalid", {63'd0, destRegValidOut}, {63'd0, m_dvalid});
        chk("ctrl_lo", ctrlOut[63:0], m_ctrl[63:0]);
        chk("ctrl_hi", ctrlOut[CTRL_W-1 -: 64], m_ctrl[CTRL_W-1 -: 64]);
        chk("error",  {63'd0, errorOut}, {63'd0, m_err});
    endtask

    task automatic do_reset();
        idle(); reset = 1'b0; step(); reset = 1'b1; step();
    endtask

    task automatic put(input logic [3:0] d, input logic [63:0] v);
        readValidIn = 1; destRegIn = d; destRegValidIn = 1; operandVal1In = v;
    endtask

    task automatic retire(input logic [3:0] r);
        idle(); wbRetireValidIn = 1; wbRetireRegIn = r; step(); idle();
    endtask

    initial begin
        model_reset();
        idle();
        // reset and idle
        do_reset();
        chk("rst_stall", {63'd0, last_stall}, 64'd0);
        chk("rst_valid", {63'd0, validOut}, 64'd0);
        put(4'd3, 64'h1122334455667788); step(); idle();
        chk("cap_valid", {63'd0, validOut}, 64'd1);
        chk("cap_op1", operandVal1Out, 64'h1122334455667788);
        // RAW hazard on R3, released the cycle after retire
        decSrc1ValidIn = 1; decSrc1In = 4'd3; step();
        chk("raw_stall", {63'd0, last_stall}, 64'd1);
        wbRetireValidIn = 1; wbRetireRegIn = 4'd3; step();
        chk("raw_ret_same", {63'd0, last_stall}, 64'd1);
        wbRetireValidIn = 0; step();
        chk("raw_release", {63'd0, last_stall}, 64'd0);
        idle();
        // backpressure then back-to-back handoff
        put(4'd4, 64'hAAAA_0000_5555_1111); step(); idle(); exReadyIn = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_stall", {63'd0, last_stall}, 64'd1);
            chk("bp_hold", operandVal1Out, 64'hAAAA_0000_5555_1111);
        end
        exReadyIn = 1; put(4'd6, 64'hBBBB_2222_CCCC_3333); step(); idle();
        chk("bp_nobubble", operandVal1Out, 64'hBBBB_2222_CCCC_3333);
        chk("bp_valid", {63'd0, validOut}, 64'd1);
        step(); retire(4'd4); retire(4'd6);
        // flush removes the captured dest count
        put(4'd5, 64'h5); step(); idle(); exReadyIn = 0; flushIn = 1; step(); idle();
        chk("fl_valid", {63'd0, validOut}, 64'd0);
        decSrc1ValidIn = 1; decSrc1In = 4'd5; step();
        chk("fl_cnt5", {63'd0, last_stall}, 64'd0);
        idle(); put(4'd8, 64'h8); flushIn = 1; step(); idle();
        chk("fl_nocap", {63'd0, validOut}, 64'd0);
        decSrc1ValidIn = 1; decSrc1In = 4'd8; step();
        chk("fl_cnt8", {63'd0, last_stall}, 64'd0);
        idle();
        // simultaneous inc/retire on R7
        put(4'd7, 64'h7); step();
        put(4'd7, 64'h77); wbRetireValidIn = 1; wbRetireRegIn = 4'd7; step(); idle();
        decSrc1ValidIn = 1; decSrc1In = 4'd7; step();
        chk("r7_held", {63'd0, last_stall}, 64'd1);
        retire(4'd7);
        decSrc1ValidIn = 1; decSrc1In = 4'd7; step();
        chk("r7_zero", {63'd0, last_stall}, 64'd0);
        idle();
        // saturation on R2
        for (int k = 0; k < 3; k++) begin put(4'd2, 64'(k)); step(); end
        idle(); decDestValidIn = 1; decDestIn = 4'd2; step();
        chk("sat_stall", {63'd0, last_stall}, 64'd1);
        idle(); step();
        // underflow error
        do_reset();
        retire(4'd9);
        chk("uf_err", {63'd0, errorOut}, 64'd1);
        decSrc1ValidIn = 1; decSrc1In = 4'd9; step();
        chk("uf_cnt", {63'd0, last_stall}, 64'd0);
        chk("uf_sticky", {63'd0, errorOut}, 64'd1);
        // read while stalled
        do_reset();
        exReadyIn = 0; put(4'd1, 64'h1); step();
        put(4'd1, 64'hDEAD); step(); idle();
        chk("rvs_err", {63'd0, errorOut}, 64'd1);
        chk("rvs_drop", operandVal1Out, 64'h1);

        // randomized traffic
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            for (int n = 0; n < 400; n++) begin
                int pick;
                bit found;
                exReadyIn = ($urandom % 4) != 0;
                flushIn = ($urandom % 20) == 0;
                decSrc1ValidIn = ($urandom % 3) == 0; decSrc1In = 4'($urandom % 6);
                decSrc2ValidIn = ($urandom % 4) == 0; decSrc2In = 4'($urandom % 6);
                decDestValidIn = ($urandom % 4) == 0; decDestIn = 4'($urandom % 6);
                operandVal1In = {$urandom, $urandom};
                operandVal2In = {$urandom, $urandom};
                destRegValueIn = {$urandom, $urandom};
                for (int k = 0; k < CTRL_W / 32; k++) ctrlIn[32*k +: 32] = $urandom;
                destRegIn = 4'($urandom % 6);
                destRegValidIn = ($urandom % 4) != 0;
                pick = int'($urandom % 16);
                found = 0;
                for (int k = 0; k < 16; k++)
                    if (!found && m_cnt[(pick + k) % 16] != 0) begin
                        found = 1; wbRetireRegIn = 4'((pick + k) % 16);
                    end
                if (found) wbRetireValidIn = ($urandom % 3) == 0;
                else begin
                    wbRetireRegIn = 4'(pick);
                    wbRetireValidIn = (seg == 3) && (($urandom % 60) == 0);
                end
                readValidIn = model_stall() ? (seg >= 2 && ($urandom % 50) == 0)
                                            : (($urandom % 3) != 0);
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
